// File: rtl/field_extract_pkg.sv
// Shared types and the field-extraction function for the field_extract_pipe slice.
package field_extract_pkg;

  typedef enum logic {
    DIR_ASC  = 1'b0,  // field bit i = data[base + i]
    DIR_DESC = 1'b1   // field bit i = data[base - FIELD_W + 1 + i]
  } dir_e;

  // Widest operand / result the shared function handles; callers zero-pad up to it.
  localparam int FE_MAX_W = 128;
  localparam int FE_IDX_W = $clog2(FE_MAX_W);

  typedef struct packed {
    logic                oor;    // at least one field bit fell outside the operand
    logic [FE_MAX_W-1:0] field;  // zero-filled, optionally sign-extended field
  } fe_result_t;

  // Extract a field_w-bit field from the low data_w bits of data at index base.
  // Out-of-range bits read as zero and flag oor; the extension bits up to out_w
  // copy the zero-filled field MSB when sext is set.
  function automatic fe_result_t fe_extract(
    input logic [FE_MAX_W-1:0] data,
    input int                  base,
    input dir_e                dir,
    input logic                sext,
    input int                  data_w,
    input int                  field_w,
    input int                  out_w
  );
    fe_result_t res;
    int         idx;
    logic       msb;
    res = '0;
    msb = 1'b0;
    idx = 0;
    for (int i = 0; i < FE_MAX_W; i++) begin
      if (i < field_w) begin
        idx = (dir == DIR_ASC) ? base + i : base - field_w + 1 + i;
        if (idx < 0 || idx >= data_w) begin
          res.oor = 1'b1;
        end else begin
          res.field[i] = data[idx[FE_IDX_W-1:0]];
        end
        if (i == field_w - 1) begin
          msb = res.field[i];
        end
      end else if (sext && i < out_w) begin
        res.field[i] = msb;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/field_extract_core.sv
// Purely combinational field extractor sitting between the two pipeline stages.
module field_extract_core
  import field_extract_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int FIELD_W = 8,
  parameter int OUT_W   = 32,
  parameter int BASE_W  = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [BASE_W-1:0] base_i,
  input  dir_e              dir_i,
  input  logic              sext_i,
  output logic [OUT_W-1:0]  field_o,
  output logic              oor_o
);

  fe_result_t res;

  // Evaluate the shared extraction function on the zero-padded operand.
  // NOTE: every always_comb output is fully assigned on every path, so no latch is inferred.
  always_comb begin
    res = fe_extract(FE_MAX_W'(data_i), int'(base_i), dir_i, sext_i, DATA_W, FIELD_W, OUT_W);
  end

  assign field_o = res.field[OUT_W-1:0];
  assign oor_o   = res.oor;

  // Result bits above OUT_W are always zero; fold them away explicitly.
  if (OUT_W < FE_MAX_W) begin : g_hi_unused
    logic unused_hi;
    assign unused_hi = ^res.field[FE_MAX_W-1:OUT_W];
  end

endmodule

// File: rtl/field_extract_pipe.sv
// Two-stage valid/ready bit-field extractor with a saturating out-of-range counter.
module field_extract_pipe
  import field_extract_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int FIELD_W = 8,
  parameter int OUT_W   = 32,
  parameter int BASE_W  = $clog2(DATA_W),
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [BASE_W-1:0] in_base,
  input  logic              in_dir,
  input  logic              in_sext,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_field,
  output logic              out_oor,
  output logic [CNT_W-1:0]  oor_count,
  input  logic              clr_count
);

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q,  s1_data_d;
  logic [BASE_W-1:0] s1_base_q,  s1_base_d;
  dir_e              s1_dir_q,   s1_dir_d;
  logic              s1_sext_q,  s1_sext_d;

  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_field_q, out_field_d;
  logic              out_oor_q,   out_oor_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  logic              s1_load, s2_load, out_hs;
  logic [OUT_W-1:0]  core_field;
  logic              core_oor;

  // Advance conditions: a stage loads when it is empty or its successor is loading.
  always_comb begin
    s2_load = !out_valid_q || out_ready;
    s1_load = !s1_valid_q || s2_load;
    out_hs  = out_valid_q && out_ready;
  end

  assign in_ready = s1_load;

  // Stage 1 next state: capture the operand on an input handshake.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_base_d  = s1_base_q;
    s1_dir_d   = s1_dir_q;
    s1_sext_d  = s1_sext_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_base_d = in_base;
        s1_dir_d  = dir_e'(in_dir);
        s1_sext_d = in_sext;
      end
    end
  end

  field_extract_core #(
    .DATA_W  (DATA_W),
    .FIELD_W (FIELD_W),
    .OUT_W   (OUT_W),
    .BASE_W  (BASE_W)
  ) u_core (
    .data_i  (s1_data_q),
    .base_i  (s1_base_q),
    .dir_i   (s1_dir_q),
    .sext_i  (s1_sext_q),
    .field_o (core_field),
    .oor_o   (core_oor)
  );

  // Stage 2 next state: register the extracted field; hold it while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    out_field_d = out_field_q;
    out_oor_d   = out_oor_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_field_d = core_field;
        out_oor_d   = core_oor;
      end
    end
  end

  // Out-of-range counter: clear wins over increment, increment saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_count) begin
      cnt_d = '0;
    end else if (out_hs && out_oor_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset; a reset drops every in-flight beat.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  // NOTE: the payload registers are reset as well because out_field has a defined reset value
  // and the state is only a handful of flops; wide storage arrays would not be reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_base_q   <= '0;
      s1_dir_q    <= DIR_ASC;
      s1_sext_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_field_q <= '0;
      out_oor_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_base_q   <= s1_base_d;
      s1_dir_q    <= s1_dir_d;
      s1_sext_q   <= s1_sext_d;
      out_valid_q <= out_valid_d;
      out_field_q <= out_field_d;
      out_oor_q   <= out_oor_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_field = out_field_q;
  assign out_oor   = out_oor_q;
  assign oor_count = cnt_q;

endmodule

// File: tb/tb_field_extract_pipe.sv
// Self-checking bench for field_extract_pipe: directed cases plus a randomized
// stream scored against a window-shift reference model.
module tb_field_extract_pipe;

  localparam int DATA_W  = 32;
  localparam int FIELD_W = 8;
  localparam int OUT_W   = 32;
  localparam int BASE_W  = 5;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [BASE_W-1:0] in_base;
  logic              in_dir;
  logic              in_sext;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_field;
  logic              out_oor;
  logic [CNT_W-1:0]  oor_count;
  logic              clr_count;

  field_extract_pipe #(
    .DATA_W  (DATA_W),
    .FIELD_W (FIELD_W),
    .OUT_W   (OUT_W),
    .BASE_W  (BASE_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_base   (in_base),
    .in_dir    (in_dir),
    .in_sext   (in_sext),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_field (out_field),
    .out_oor   (out_oor),
    .oor_count (oor_count),
    .clr_count (clr_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        oor;
    logic [31:0] field;
  } exp_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  base;
    logic        dir;
    logic        sext;
  } beat_t;

  exp_t  exp_q[$];
  beat_t beats[$];
  int    mcnt  = 0;
  int    n_out = 0;

  // Reference: place the operand in a zero-padded window and shift the field's
  // lowest index down to bit 0; out of range when the span leaves [0, DATA_W-1].
  function automatic exp_t ref_model(input logic [31:0] d, input logic [4:0] base,
                                     input logic dir, input logic sext);
    int          lo;
    logic [95:0] pad;
    logic [95:0] win;
    exp_t        r;
    lo      = dir ? int'(base) - (FIELD_W - 1) : int'(base);
    pad     = {32'b0, d, 32'b0};
    win     = pad >> (lo + 32);
    r.field = {24'b0, win[7:0]};
    if (sext && win[7]) r.field[31:8] = '1;
    r.oor   = (lo < 0) || (lo + FIELD_W - 1 > DATA_W - 1);
    return r;
  endfunction

  // Scoreboard: record accepted inputs, compare every delivered output in order,
  // and track the expected counter value.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      exp_q.delete();
      mcnt = 0;
    end else begin
      check("oor_count", 64'(oor_count), 64'(mcnt));
      if (out_valid && out_ready) begin
        n_out++;
        check("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_field", 64'(out_field), 64'(e.field));
          check("sb_oor", 64'(out_oor), 64'(e.oor));
          if (e.oor && !clr_count && mcnt < CNT_MAX) mcnt++;
        end
      end
      if (clr_count) mcnt = 0;
      if (in_valid && in_ready) exp_q.push_back(ref_model(in_data, in_base, in_dir, in_sext));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single beat into an empty pipe with out_ready high; checks 2-cycle latency
  // and the literal expected result.
  task automatic send_lat(input logic [31:0] d, input logic [4:0] b, input logic dir,
                          input logic sx, input logic [31:0] exp_field, input logic exp_oor,
                          input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    in_data  = d;
    in_base  = b;
    in_dir   = dir;
    in_sext  = sx;
    tick();
    in_valid = 1'b0;
    check({tag, "_lat1_valid"}, 64'(out_valid), 64'(0));
    tick();
    check({tag, "_lat2_valid"}, 64'(out_valid), 64'(1));
    check({tag, "_field"}, 64'(out_field), 64'(exp_field));
    check({tag, "_oor"}, 64'(out_oor), 64'(exp_oor));
  endtask

  // Offer queued beats for a number of cycles; rnd adds valid gaps, random
  // backpressure and occasional counter clears.
  task automatic pump(input int budget, input bit rnd);
    for (int c = 0; c < budget; c++) begin
      if (rnd) begin
        out_ready = 1'($urandom_range(0, 1));
        clr_count = ($urandom_range(0, 31) == 0);
      end
      in_valid = (beats.size() != 0) && (!rnd || $urandom_range(0, 3) != 0);
      if (beats.size() != 0) begin
        in_data = beats[0].data;
        in_base = beats[0].base;
        in_dir  = beats[0].dir;
        in_sext = beats[0].sext;
      end
      @(negedge clk);
      if (in_valid && in_ready) beats.delete(0);
      tick();
    end
    in_valid  = 1'b0;
    clr_count = 1'b0;
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    b.data = $urandom;
    b.base = 5'($urandom_range(0, 31));
    b.dir  = 1'($urandom_range(0, 1));
    b.sext = 1'($urandom_range(0, 1));
    return b;
  endfunction

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin : stim
    beat_t b0;
    exp_t  e0;
    int    n0;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_base   = '0;
    in_dir    = 1'b0;
    in_sext   = 1'b0;
    out_ready = 1'b1;
    clr_count = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_field", 64'(out_field), 64'(0));
    check("rst_out_oor", 64'(out_oor), 64'(0));
    check("rst_oor_count", 64'(oor_count), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // Directed extraction cases.
    send_lat(32'hA5C3_0F96, 5'd4,  1'b0, 1'b0, 32'h0000_00F9, 1'b0, "asc4");
    send_lat(32'hA5C3_0F96, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFA5, 1'b0, "desc31_sx");
    send_lat(32'hA5C3_0F96, 5'd31, 1'b1, 1'b0, 32'h0000_00A5, 1'b0, "desc31_zx");
    send_lat(32'hA5C3_0F96, 5'd28, 1'b0, 1'b0, 32'h0000_000A, 1'b1, "asc28_oor");
    tick();
    check("cnt_after_1", 64'(oor_count), 64'(1));
    send_lat(32'hA5C3_0F96, 5'd3,  1'b1, 1'b0, 32'h0000_0060, 1'b1, "desc3_oor");
    tick();
    check("cnt_after_2", 64'(oor_count), 64'(2));

    // Backpressure: four back-to-back beats against a stalled output.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beats.push_back(rand_beat());
    b0 = beats[0];
    e0 = ref_model(b0.data, b0.base, b0.dir, b0.sext);
    pump(6, 1'b0);
    check("bp_accepted", 64'(4 - beats.size()), 64'(2));
    check("bp_in_ready", 64'(in_ready), 64'(0));
    check("bp_valid", 64'(out_valid), 64'(1));
    check("bp_hold_field", 64'(out_field), 64'(e0.field));
    tick();
    check("bp_hold_field2", 64'(out_field), 64'(e0.field));
    out_ready = 1'b1;
    n0 = n_out;
    pump(12, 1'b0);
    check("bp_delivered", 64'(n_out - n0), 64'(4));
    check("bp_sb_empty", 64'(exp_q.size()), 64'(0));

    // Counter saturation and clear priority.
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    check("cnt_cleared", 64'(oor_count), 64'(0));
    for (int i = 0; i < 5; i++) begin
      b0      = rand_beat();
      b0.base = 5'd28;
      b0.dir  = 1'b0;
      beats.push_back(b0);
    end
    pump(12, 1'b0);
    check("cnt_saturated", 64'(oor_count), 64'(CNT_MAX));
    send_lat(32'hA5C3_0F96, 5'd28, 1'b0, 1'b0, 32'h0000_000A, 1'b1, "clr_hs");
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    check("cnt_clr_priority", 64'(oor_count), 64'(0));

    // Mid-stream reset with both stages full.
    out_ready = 1'b0;
    beats.push_back(rand_beat());
    beats.push_back(rand_beat());
    pump(3, 1'b0);
    check("mr_full_valid", 64'(out_valid), 64'(1));
    check("mr_full_in_ready", 64'(in_ready), 64'(0));
    beats.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_flush_valid", 64'(out_valid), 64'(0));
    check("mr_in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mr_no_stale", 64'(out_valid), 64'(0));
    end
    send_lat(32'hA5C3_0F96, 5'd4, 1'b0, 1'b0, 32'h0000_00F9, 1'b0, "mr_relat");
    tick();

    // Randomized stream with random backpressure and clears.
    for (int i = 0; i < 300; i++) beats.push_back(rand_beat());
    pump(1500, 1'b1);
    check("rnd_stim_consumed", 64'(beats.size()), 64'(0));
    out_ready = 1'b1;
    pump(10, 1'b0);
    check("rnd_sb_drained", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
